bist_for_switch: RTL and testbench

- Built-in self-test for the board's four slide switches, companion to the LED self-test.
- After `start`, the block steps through each switch and shows on the LEDs which switch to move. For every switch it checks that the switch goes high and then low with no other switch moving.
- It finishes in a pass or fail state. On fail it reports the failing switch index.
- It sits between the raw `sw` pins and the `led` driver mux.

---
 rtl/bist_pkg.sv | 26 ++
 rtl/sw_debounce.sv | 53 +++++
 rtl/bist_for_switch.sv | 169 ++++++++++++++++
 tb/tb_bist_for_switch.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared definitions for the switch self-test.
//   N_SW     : number of slide switches under test
//   LED_PASS : LED pattern shown once every switch has been exercised
//   state_e  : self-test FSM states
//   onehot() : LED / expected-switch pattern for a switch index
package bist_pkg;

    localparam int N_SW = 4;
    localparam logic [N_SW-1:0] LED_PASS = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARM      = 3'd1,
        ST_PROBE_HI = 3'd2,
        ST_PROBE_LO = 3'd3,
        ST_PASS     = 3'd4,
        ST_FAIL     = 3'd5
    } state_e;

    function automatic logic [N_SW-1:0] onehot(input logic [1:0] i);
        logic [N_SW-1:0] one;
        one = {{(N_SW-1){1'b0}}, 1'b1};
        return one << i;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Single-bit input conditioner: two-flop synchronizer followed by a
// debounce counter.
//   clk, rst_n : clock, async active-low reset
//   raw_i      : raw switch pin, asynchronous to clk
//   db_o       : debounced level; changes only after DEBOUNCE_CYCLES
//                consecutive synchronized samples that differ from it
module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic db_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s2_q;
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any sample that agrees with the current output restarts the run,
    // so a pulse shorter than DEBOUNCE_CYCLES never flips db.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (s2_q != db_q) begin
            if (cnt_q == CNT_MAX) begin
                db_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= raw_i;
            s2_q  <= s1_q;
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    assign db_o = db_q;

endmodule

// File: rtl/bist_for_switch.sv
// Built-in self-test for the four slide switches. After start the operator
// is prompted on the LEDs to raise, then lower, each switch in turn; any
// other switch moving, or a step taking too long, ends in FAIL.
//   clk, rst_n : clock, async active-low reset
//   sw         : raw switch pins (asynchronous)
//   start      : level-sampled start request, ignored while busy
//   led        : prompt / result display
//   busy       : test in progress
//   pass, fail : sticky result flags, cleared by the next start
//   fail_idx   : switch being probed when the failure happened
// All outputs are registered and derived from the next-state values so they
// change on the same edge as the FSM.
module bist_for_switch
    import bist_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 50_000_000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_SW-1:0] sw,
    input  logic            start,
    output logic [N_SW-1:0] led,
    output logic            busy,
    output logic            pass,
    output logic            fail,
    output logic [1:0]      fail_idx
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMR_MAX = TW'(TIMEOUT_CYCLES - 1);

    logic [N_SW-1:0] db;

    for (genvar g = 0; g < N_SW; g++) begin : g_db
        sw_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (clk),
            .rst_n(rst_n),
            .raw_i(sw[g]),
            .db_o (db[g])
        );
    end

    state_e          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [N_SW-1:0] led_q, led_d;
    logic            busy_q, busy_d;
    logic            pass_q, pass_d;
    logic            fail_q, fail_d;
    logic [1:0]      fidx_q, fidx_d;

    logic [N_SW-1:0] want;
    logic            other;
    logic            tmo;
    logic            running;

    assign want    = onehot(idx_q);
    assign other   = |(db & ~want);
    assign tmo     = (timer_q == TMR_MAX);
    assign running = (state_q == ST_ARM) || (state_q == ST_PROBE_HI) ||
                     (state_q == ST_PROBE_LO);

    // Each probe state checks, in order: wrong switch, exit condition, timeout.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ARM;
                    idx_d   = 2'd0;
                end
            end
            ST_ARM: begin
                idx_d = 2'd0;
                if (db == '0)  state_d = ST_PROBE_HI;
                else if (tmo)  state_d = ST_FAIL;
            end
            ST_PROBE_HI: begin
                if (other)             state_d = ST_FAIL;
                else if (db == want)   state_d = ST_PROBE_LO;
                else if (tmo)          state_d = ST_FAIL;
            end
            ST_PROBE_LO: begin
                if (other) begin
                    state_d = ST_FAIL;
                end else if (db == '0) begin
                    if (idx_q == 2'd3) begin
                        state_d = ST_PASS;
                    end else begin
                        state_d = ST_PROBE_HI;
                        idx_d   = idx_q + 2'd1;
                    end
                end else if (tmo) begin
                    state_d = ST_FAIL;
                end
            end
            ST_PASS, ST_FAIL: begin
                if (start) begin
                    state_d = ST_ARM;
                    idx_d   = 2'd0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Timer restarts on every state change; it never reaches past TMR_MAX
    // because hitting TMR_MAX always forces a transition.
    always_comb begin
        timer_d = '0;
        if (running && state_d == state_q && !tmo) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_comb begin
        led_d  = '0;
        busy_d = 1'b0;
        pass_d = 1'b0;
        fail_d = 1'b0;
        fidx_d = 2'd0;
        unique case (state_d)
            ST_IDLE:     ;
            ST_ARM:      busy_d = 1'b1;
            ST_PROBE_HI: begin busy_d = 1'b1; led_d = onehot(idx_d);  end
            ST_PROBE_LO: begin busy_d = 1'b1; led_d = ~onehot(idx_d); end
            ST_PASS:     begin pass_d = 1'b1; led_d = LED_PASS;       end
            ST_FAIL:     begin
                fail_d = 1'b1;
                fidx_d = idx_d;
                led_d  = onehot(idx_d);
            end
            default:     ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            timer_q <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            fidx_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            fidx_q  <= fidx_d;
        end
    end

    assign led      = led_q;
    assign busy     = busy_q;
    assign pass     = pass_q;
    assign fail     = fail_q;
    assign fail_idx = fidx_q;

endmodule

// File: tb/tb_bist_for_switch.sv
module tb_bist_for_switch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw;
    logic       start;
    logic [3:0] led;
    logic       busy, pass, fail;
    logic [1:0] fail_idx;

    int checks = 0;
    int errors = 0;

    bist_for_switch #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (200)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw      (sw),
        .start   (start),
        .led     (led),
        .busy    (busy),
        .pass    (pass),
        .fail    (fail),
        .fail_idx(fail_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sw;
        logic       start;
        int         cyc;
        logic [3:0] led;
        logic       busy;
        logic       pass;
        logic       fail;
        logic [1:0] fidx;
    } vec_t;

    vec_t tbl[25];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Outputs packed as {led, busy, pass, fail, fail_idx}
    task automatic check(input string name, input logic [8:0] exp);
        logic [8:0] got;
        got = {led, busy, pass, fail, fail_idx};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got led=%b busy=%b pass=%b fail=%b idx=%0d, expected led=%b busy=%b pass=%b fail=%b idx=%0d",
                     name, got[8:5], got[4], got[3], got[2], got[1:0],
                     exp[8:5], exp[4], exp[3], exp[2], exp[1:0]);
        end
    endtask

    initial begin
        int n;
        // sw, start, cycles -> led, busy, pass, fail, fail_idx
        // happy path (start also raised mid-test to show it is ignored)
        tbl[0]  = '{4'b0000, 1, 1,  4'b0000, 1, 0, 0, 0};
        tbl[1]  = '{4'b0000, 0, 1,  4'b0001, 1, 0, 0, 0};
        tbl[2]  = '{4'b0001, 0, 10, 4'b1110, 1, 0, 0, 0};
        tbl[3]  = '{4'b0000, 0, 10, 4'b0010, 1, 0, 0, 0};
        tbl[4]  = '{4'b0010, 0, 10, 4'b1101, 1, 0, 0, 0};
        tbl[5]  = '{4'b0000, 1, 10, 4'b0100, 1, 0, 0, 0};
        tbl[6]  = '{4'b0100, 0, 10, 4'b1011, 1, 0, 0, 0};
        tbl[7]  = '{4'b0000, 0, 10, 4'b1000, 1, 0, 0, 0};
        tbl[8]  = '{4'b1000, 0, 10, 4'b0111, 1, 0, 0, 0};
        tbl[9]  = '{4'b0000, 0, 10, 4'b1111, 0, 1, 0, 0};
        // wrong switch while probing idx=1
        tbl[10] = '{4'b0000, 1, 1,  4'b0000, 1, 0, 0, 0};
        tbl[11] = '{4'b0000, 0, 1,  4'b0001, 1, 0, 0, 0};
        tbl[12] = '{4'b0001, 0, 10, 4'b1110, 1, 0, 0, 0};
        tbl[13] = '{4'b0000, 0, 10, 4'b0010, 1, 0, 0, 0};
        tbl[14] = '{4'b0100, 0, 10, 4'b0010, 0, 0, 1, 1};
        tbl[15] = '{4'b0000, 0, 10, 4'b0010, 0, 0, 1, 1};
        // glitch on sw3 at idx=0, then progress to PROBE_LO idx=2
        tbl[16] = '{4'b0000, 1, 1,  4'b0000, 1, 0, 0, 0};
        tbl[17] = '{4'b0000, 0, 1,  4'b0001, 1, 0, 0, 0};
        tbl[18] = '{4'b1000, 0, 3,  4'b0001, 1, 0, 0, 0};
        tbl[19] = '{4'b0000, 0, 10, 4'b0001, 1, 0, 0, 0};
        tbl[20] = '{4'b0001, 0, 10, 4'b1110, 1, 0, 0, 0};
        tbl[21] = '{4'b0000, 0, 10, 4'b0010, 1, 0, 0, 0};
        tbl[22] = '{4'b0010, 0, 10, 4'b1101, 1, 0, 0, 0};
        tbl[23] = '{4'b0000, 0, 10, 4'b0100, 1, 0, 0, 0};
        tbl[24] = '{4'b0100, 0, 10, 4'b1011, 1, 0, 0, 0};

        // reset with switches set
        rst_n = 1'b0;
        sw    = 4'b1010;
        start = 1'b0;
        tick(3);
        check("reset", 9'b0);
        rst_n = 1'b1;
        tick(8);
        check("idle_no_start", 9'b0);
        sw = 4'b0000;
        tick(10);

        for (int i = 0; i < 25; i++) begin
            sw    = tbl[i].sw;
            start = tbl[i].start;
            tick(tbl[i].cyc);
            check($sformatf("row%0d", i),
                  {tbl[i].led, tbl[i].busy, tbl[i].pass, tbl[i].fail, tbl[i].fidx});
        end
        start = 1'b0;

        // reset mid-test in PROBE_LO idx=2: takes effect without a clock edge
        rst_n = 1'b0;
        #2;
        check("mid_reset", 9'b0);
        sw = 4'b0000;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        check("after_reset_idle", 9'b0);

        // restart begins at idx 0, then time out in PROBE_HI
        start = 1'b1;
        tick(1);
        check("restart_arm", {4'b0000, 1'b1, 1'b0, 1'b0, 2'd0});
        start = 1'b0;
        tick(1);
        check("restart_idx0", {4'b0001, 1'b1, 1'b0, 1'b0, 2'd0});
        n = 0;
        while (!fail && n < 300) begin
            tick(1);
            n++;
        end
        checks++;
        if (n != 200) begin
            errors++;
            $display("FAIL timeout_cycles: got %0d, expected 200", n);
        end
        check("timeout_result", {4'b0001, 1'b0, 1'b0, 1'b1, 2'd0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
